// File: rtl/spi_bus_arbiter_if.sv
// -----------------------------------------------------------------------------
// spi_bus_arbiter_if
// Bundles the signals between two SPI requesters, the shared SPI memory and
// the arbiter that multiplexes them.
//   Requester side : reqN_sel_n, reqN_out, reqN_clk_en  (to arbiter)
//                    gntN, reqN_data_in, abortN         (from arbiter)
//   Memory side    : spi_data_in                        (to arbiter)
//                    spi_select, spi_out, spi_clk_enable (from arbiter)
// Modports:
//   slave  - the arbiter itself
//   master - requesters and memory model driving the arbiter
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

interface spi_bus_arbiter_if;
  logic req0_sel_n;
  logic req1_sel_n;
  logic req0_out;
  logic req1_out;
  logic req0_clk_en;
  logic req1_clk_en;
  logic gnt0;
  logic gnt1;
  logic req0_data_in;
  logic req1_data_in;
  logic abort0;
  logic abort1;
  logic spi_data_in;
  logic spi_select;
  logic spi_out;
  logic spi_clk_enable;

  modport slave (
    input  req0_sel_n, req1_sel_n, req0_out, req1_out,
    input  req0_clk_en, req1_clk_en, spi_data_in,
    output gnt0, gnt1, req0_data_in, req1_data_in, abort0, abort1,
    output spi_select, spi_out, spi_clk_enable
  );

  modport master (
    output req0_sel_n, req1_sel_n, req0_out, req1_out,
    output req0_clk_en, req1_clk_en, spi_data_in,
    input  gnt0, gnt1, req0_data_in, req1_data_in, abort0, abort1,
    input  spi_select, spi_out, spi_clk_enable
  );
endinterface

// File: rtl/spi_bus_arbiter.sv
// -----------------------------------------------------------------------------
// spi_bus_arbiter
// Shares one SPI memory between two requesters. A requester asks for the bus
// by pulling its chip-select low; the arbiter grants round-robin, passes the
// owner's select/data/clock-enable straight through to the memory, enforces a
// deselected gap between owners and optionally forces a release after a
// maximum ownership length.
// Parameters:
//   GAP_CYCLES     - deselected cycles between two ownerships (1..15)
//   TIMEOUT_CYCLES - maximum ownership length in cycles, 0 = unlimited
// Ports:
//   clk  - sole clock, rising edge
//   rstn - synchronous active-low reset
//   bus  - requester/memory signal bundle (slave modport)
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module spi_bus_arbiter #(
  parameter int GAP_CYCLES     = 2,
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic               clk,
  input  logic               rstn,
  spi_bus_arbiter_if.slave   bus
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] OWN0 = 2'd1;
  localparam logic [1:0] OWN1 = 2'd2;
  localparam logic [1:0] GAP  = 2'd3;

  localparam logic [3:0]  GAP_LAST   = 4'(GAP_CYCLES - 1);
  localparam logic        TIMEOUT_EN = (TIMEOUT_CYCLES != 0);
  localparam logic [15:0] HOLD_LAST  = TIMEOUT_EN ? 16'(TIMEOUT_CYCLES - 1) : 16'd0;

  logic [1:0]  state;
  logic [3:0]  gap_cnt;
  logic [15:0] hold_cnt;
  logic        last_owner;
  logic        blocked0;
  logic        blocked1;
  logic        abort0_pulse;
  logic        abort1_pulse;

  logic own0;
  logic own1;
  logic elig0;
  logic elig1;
  logic any_elig;
  logic pick1;

  assign own0 = (state == OWN0);
  assign own1 = (state == OWN1);

  // A requester that was timed out stays ineligible until it deselects once.
  assign elig0    = !bus.req0_sel_n && !blocked0;
  assign elig1    = !bus.req1_sel_n && !blocked1;
  assign any_elig = elig0 || elig1;
  // On a tie the requester that did not own the bus last time wins.
  assign pick1    = elig1 && (!elig0 || !last_owner);

  // Arbitration state machine, counters, eligibility and abort pulses.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state        <= IDLE;
      gap_cnt      <= 4'd0;
      hold_cnt     <= 16'd0;
      last_owner   <= 1'b1;
      blocked0     <= 1'b0;
      blocked1     <= 1'b0;
      abort0_pulse <= 1'b0;
      abort1_pulse <= 1'b0;
    end else begin
      abort0_pulse <= 1'b0;
      abort1_pulse <= 1'b0;
      if (bus.req0_sel_n) blocked0 <= 1'b0;
      if (bus.req1_sel_n) blocked1 <= 1'b0;

      case (state)
        IDLE: begin
          if (any_elig) begin
            state      <= pick1 ? OWN1 : OWN0;
            last_owner <= pick1;
            hold_cnt   <= 16'd0;
          end
        end
        OWN0: begin
          if (bus.req0_sel_n) begin
            state   <= GAP;
            gap_cnt <= 4'd0;
          end else if (TIMEOUT_EN && (hold_cnt == HOLD_LAST)) begin
            state        <= GAP;
            gap_cnt      <= 4'd0;
            abort0_pulse <= 1'b1;
            blocked0     <= 1'b1;
          end else if (TIMEOUT_EN) begin
            hold_cnt <= hold_cnt + 16'd1;
          end
        end
        OWN1: begin
          if (bus.req1_sel_n) begin
            state   <= GAP;
            gap_cnt <= 4'd0;
          end else if (TIMEOUT_EN && (hold_cnt == HOLD_LAST)) begin
            state        <= GAP;
            gap_cnt      <= 4'd0;
            abort1_pulse <= 1'b1;
            blocked1     <= 1'b1;
          end else if (TIMEOUT_EN) begin
            hold_cnt <= hold_cnt + 16'd1;
          end
        end
        GAP: begin
          // Requests raised during the gap wait here; the last gap cycle
          // arbitrates exactly as IDLE would.
          if (gap_cnt == GAP_LAST) begin
            if (any_elig) begin
              state      <= pick1 ? OWN1 : OWN0;
              last_owner <= pick1;
              hold_cnt   <= 16'd0;
            end else begin
              state <= IDLE;
            end
          end else begin
            gap_cnt <= gap_cnt + 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Grants are decodes of the state register, so they change only on edges.
  assign bus.gnt0   = own0;
  assign bus.gnt1   = own1;
  assign bus.abort0 = abort0_pulse;
  assign bus.abort1 = abort1_pulse;

  // Owner's signals pass straight through; otherwise the memory is deselected.
  assign bus.spi_select     = own0 ? bus.req0_sel_n : (own1 ? bus.req1_sel_n : 1'b1);
  assign bus.spi_out        = (own0 & bus.req0_out)    | (own1 & bus.req1_out);
  assign bus.spi_clk_enable = (own0 & bus.req0_clk_en) | (own1 & bus.req1_clk_en);

  assign bus.req0_data_in = own0 & bus.spi_data_in;
  assign bus.req1_data_in = own1 & bus.spi_data_in;

endmodule

// File: tb/tb_spi_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_spi_bus_arbiter
// Table-driven bench for spi_bus_arbiter. Instance A uses GAP_CYCLES=2 and
// TIMEOUT_CYCLES=8; instance B uses GAP_CYCLES=1 and TIMEOUT_CYCLES=0.
// Input vector  : {rstn, sel0_n, sel1_n, out0, out1, clk_en0, clk_en1, spi_din}
// Output vector : {gnt0, gnt1, abort0, abort1, spi_select, spi_out,
//                  spi_clk_enable, req0_data_in, req1_data_in}
// Each vector is driven on a falling edge, held across one rising edge, and
// the outputs are compared on the next falling edge with the inputs still on.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_spi_bus_arbiter;

  typedef struct {
    string      name;
    logic [7:0] in;
    logic [8:0] exp;
  } vec_t;

  logic clk = 1'b0;
  logic rstn_a;
  logic rstn_b;

  always #5 clk = ~clk;

  spi_bus_arbiter_if bus_a ();
  spi_bus_arbiter_if bus_b ();

  spi_bus_arbiter #(.GAP_CYCLES(2), .TIMEOUT_CYCLES(8)) dut_a (
    .clk  (clk),
    .rstn (rstn_a),
    .bus  (bus_a.slave)
  );

  spi_bus_arbiter #(.GAP_CYCLES(1), .TIMEOUT_CYCLES(0)) dut_b (
    .clk  (clk),
    .rstn (rstn_b),
    .bus  (bus_b.slave)
  );

  int         n_vec  = 0;
  int         n_miss = 0;
  int         excl_viol = 0;
  vec_t       tbl[$];
  logic [8:0] exp_q[$];
  string      name_q[$];

  localparam logic [8:0] DESEL = 9'b0_0_0_0_1_0_0_0_0;
  localparam logic [8:0] OWN0Q = 9'b1_0_0_0_0_0_0_0_0;
  localparam logic [8:0] OWN1Q = 9'b0_1_0_0_0_0_0_0_0;

  // Grants and aborts must be mutually exclusive on both instances.
  always @(negedge clk) begin
    if ((bus_a.gnt0 === 1'b1 && bus_a.gnt1 === 1'b1) ||
        (bus_a.abort0 === 1'b1 && bus_a.abort1 === 1'b1) ||
        (bus_b.gnt0 === 1'b1 && bus_b.gnt1 === 1'b1) ||
        (bus_b.abort0 === 1'b1 && bus_b.abort1 === 1'b1))
      excl_viol++;
  end

  task automatic add(input string name, input logic [7:0] in, input logic [8:0] exp);
    vec_t v;
    v.name = name;
    v.in   = in;
    v.exp  = exp;
    tbl.push_back(v);
  endtask

  task automatic drive(input bit which, input logic [7:0] in);
    if (!which) begin
      rstn_a = in[7];
      bus_a.req0_sel_n = in[6]; bus_a.req1_sel_n = in[5];
      bus_a.req0_out = in[4];   bus_a.req1_out = in[3];
      bus_a.req0_clk_en = in[2]; bus_a.req1_clk_en = in[1];
      bus_a.spi_data_in = in[0];
    end else begin
      rstn_b = in[7];
      bus_b.req0_sel_n = in[6]; bus_b.req1_sel_n = in[5];
      bus_b.req0_out = in[4];   bus_b.req1_out = in[3];
      bus_b.req0_clk_en = in[2]; bus_b.req1_clk_en = in[1];
      bus_b.spi_data_in = in[0];
    end
  endtask

  function automatic logic [8:0] sample(input bit which);
    if (!which)
      return {bus_a.gnt0, bus_a.gnt1, bus_a.abort0, bus_a.abort1, bus_a.spi_select,
              bus_a.spi_out, bus_a.spi_clk_enable, bus_a.req0_data_in, bus_a.req1_data_in};
    else
      return {bus_b.gnt0, bus_b.gnt1, bus_b.abort0, bus_b.abort1, bus_b.spi_select,
              bus_b.spi_out, bus_b.spi_clk_enable, bus_b.req0_data_in, bus_b.req1_data_in};
  endfunction

  task automatic apply(input bit which, input string name, input logic [7:0] in,
                       input logic [8:0] exp);
    logic [8:0] got;
    logic [8:0] want;
    string      nm;
    drive(which, in);
    exp_q.push_back(exp);
    name_q.push_back(name);
    @(negedge clk);
    got  = sample(which);
    want = exp_q.pop_front();
    nm   = name_q.pop_front();
    n_vec++;
    if (got !== want) begin
      n_miss++;
      $display("FAIL %s: got %b expected %b", nm, got, want);
    end
  endtask

  task automatic check_int(input string name, input int got, input int want);
    n_vec++;
    if (got != want) begin
      n_miss++;
      $display("FAIL %s: got %0d expected %0d", name, got, want);
    end
  endtask

  initial begin
    int aborts_b;
    int lost_b;

    drive(1'b0, 8'b0_1_1_0_0_0_0_0);
    drive(1'b1, 8'b0_1_1_0_0_0_0_0);

    // reset, tie-break, pass-through and gap
    add("rst",        8'b0_1_1_0_0_0_0_0, DESEL);
    add("rst_din",    8'b0_1_1_0_0_0_0_1, DESEL);
    add("idle",       8'b1_1_1_0_0_0_0_0, DESEL);
    add("tie_first",  8'b1_0_0_0_0_0_0_0, OWN0Q);
    add("own0_pass",  8'b1_0_0_1_0_1_0_1, 9'b1_0_0_0_0_1_1_1_0);
    add("own0_mask1", 8'b1_0_0_0_1_0_1_1, 9'b1_0_0_0_0_0_0_1_0);
    add("rel0_gap1",  8'b1_1_0_0_0_0_0_0, DESEL);
    add("gap2",       8'b1_1_0_0_0_0_0_1, DESEL);
    add("gnt1",       8'b1_1_0_0_0_0_0_0, OWN1Q);
    // spi_data_in mirrored to the owner only
    add("own1_d1",    8'b1_1_0_0_1_0_1_1, 9'b0_1_0_0_0_1_1_0_1);
    add("own1_d0",    8'b1_1_0_1_0_1_0_0, OWN1Q);
    add("own1_d1b",   8'b1_1_0_0_1_0_1_1, 9'b0_1_0_0_0_1_1_0_1);
    // round robin with req0 always asking
    add("own1_req0",  8'b1_0_0_0_0_0_0_0, OWN1Q);
    add("rel1_gap",   8'b1_0_1_0_0_0_0_0, DESEL);
    add("gap_pend",   8'b1_0_0_0_0_0_0_0, DESEL);
    add("rr_gnt0",    8'b1_0_0_0_0_0_0_0, OWN0Q);
    add("rel0",       8'b1_1_0_0_0_0_0_0, DESEL);
    add("gap_pend2",  8'b1_0_0_0_0_0_0_0, DESEL);
    add("rr_gnt1",    8'b1_0_0_0_0_0_0_0, OWN1Q);
    add("rel1",       8'b1_0_1_0_0_0_0_0, DESEL);
    add("gap_pend3",  8'b1_0_0_0_0_0_0_0, DESEL);
    add("rr_gnt0b",   8'b1_0_0_0_0_0_0_0, OWN0Q);
    // reset in the middle of a req0 transfer
    add("xfer0",      8'b1_0_0_1_0_1_0_1, 9'b1_0_0_0_0_1_1_1_0);
    add("rst_mid",    8'b0_0_0_1_0_1_0_1, DESEL);
    add("post_rst",   8'b1_1_1_0_0_0_0_0, DESEL);
    add("regrant",    8'b1_0_1_0_0_0_0_0, OWN0Q);
    add("rel_rg",     8'b1_1_1_0_0_0_0_0, DESEL);
    add("gap_rg",     8'b1_1_1_0_0_0_0_0, DESEL);
    add("to_idle",    8'b1_1_1_0_0_0_0_0, DESEL);

    @(negedge clk);
    foreach (tbl[i]) apply(1'b0, tbl[i].name, tbl[i].in, tbl[i].exp);

    // timeout after 8 owned cycles, req0 held off until it deselects
    apply(1'b0, "to_gnt0", 8'b1_0_1_0_0_0_0_0, OWN0Q);
    for (int k = 0; k < 7; k++) apply(1'b0, "to_hold", 8'b1_0_0_0_0_0_0_0, OWN0Q);
    apply(1'b0, "to_abort",   8'b1_0_0_0_0_0_0_0, 9'b0_0_1_0_1_0_0_0_0);
    apply(1'b0, "to_gap2",    8'b1_0_0_0_0_0_0_0, DESEL);
    apply(1'b0, "to_gnt1",    8'b1_0_0_0_0_0_0_0, OWN1Q);
    apply(1'b0, "to_rel1",    8'b1_0_1_0_0_0_0_0, DESEL);
    apply(1'b0, "to_gap",     8'b1_0_1_0_0_0_0_0, DESEL);
    apply(1'b0, "to_blk_gap", 8'b1_0_1_0_0_0_0_0, DESEL);
    apply(1'b0, "to_blk_idle",8'b1_0_1_0_0_0_0_0, DESEL);
    apply(1'b0, "to_unblock", 8'b1_1_1_0_0_0_0_0, DESEL);
    apply(1'b0, "to_regrant", 8'b1_0_1_0_0_0_0_0, OWN0Q);
    apply(1'b0, "to_rel",     8'b1_1_1_0_0_0_0_0, DESEL);

    // instance B: no timeout, single-cycle gap
    apply(1'b1, "b_rst",  8'b0_1_1_0_0_0_0_0, DESEL);
    apply(1'b1, "b_gnt0", 8'b1_0_1_0_0_0_0_0, OWN0Q);
    aborts_b = 0;
    lost_b   = 0;
    drive(1'b1, 8'b1_0_0_0_0_0_0_0);
    for (int k = 0; k < 70000; k++) begin
      @(negedge clk);
      if (bus_b.abort0 !== 1'b0 || bus_b.abort1 !== 1'b0) aborts_b++;
      if (bus_b.gnt0 !== 1'b1) lost_b++;
    end
    check_int("b_no_abort", aborts_b, 0);
    check_int("b_retained", lost_b, 0);
    apply(1'b1, "b_rel_gap", 8'b1_1_0_0_0_0_0_0, DESEL);
    apply(1'b1, "b_gnt1",    8'b1_1_0_0_0_0_0_0, OWN1Q);

    check_int("exclusive", excl_viol, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
